// File: rtl/iter_mul_shift_unit_if.sv
// Request/response bundle for the iterative multiply/shift unit.
// Handshake: the requester raises start with op/data1/data2 stable; the unit
// samples them on a posedge only while busy=0, then keeps busy=1 until the
// cycle after done. done=1 for exactly one cycle marks result/result_hi valid.
interface iter_mul_shift_unit_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] data1;
  logic [WIDTH-1:0] data2;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             busy;
  logic             done;

  modport master (
    output start, op, data1, data2,
    input  result, result_hi, busy, done
  );

  modport slave (
    input  start, op, data1, data2,
    output result, result_hi, busy, done
  );
endinterface

// File: rtl/iter_mul_shift_unit.sv
// Multi-cycle execution unit: unsigned shift-add multiply and bit-serial
// SLL/SRL/ROR, one step per clock. Results are only published on the edge
// that enters DONE, so intermediate values never reach result/result_hi.
module iter_mul_shift_unit #(
  parameter int WIDTH = 8,
  parameter int CNTW  = 4
) (
  input  logic                     CLK,
  input  logic                     RESET,
  iter_mul_shift_unit_if.slave     bus,
  output logic [1:0]               state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [1:0] OP_MUL = 2'b00;
  localparam logic [1:0] OP_SLL = 2'b01;
  localparam logic [1:0] OP_SRL = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  localparam logic [WIDTH-1:0] W_VAL = WIDTH'(WIDTH);

  state_t               state_q;
  logic [1:0]           op_q;
  logic [WIDTH-1:0]     mcand_q;
  // MUL: {partial high, multiplier/low product}; shifts use the low half.
  logic [2*WIDTH-1:0]   acc_q;
  logic [CNTW-1:0]      cnt_q;
  logic [WIDTH-1:0]     result_q;
  logic [WIDTH-1:0]     result_hi_q;
  logic                 busy_q;
  logic                 done_q;

  logic [WIDTH-1:0]     n_full;
  logic [CNTW-1:0]      n_load;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  logic [WIDTH-1:0]     shift_next;
  logic [2*WIDTH-1:0]   step_next;

  assign bus.result    = result_q;
  assign bus.result_hi = result_hi_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign state_dbg     = state_q;

  // Step count for a new request; over-long logical shifts run WIDTH steps,
  // which flushes the value to zero. Rotates wrap modulo WIDTH.
  always_comb begin
    n_full = '0;
    case (bus.op)
      OP_MUL:  n_full = W_VAL;
      OP_SLL,
      OP_SRL:  n_full = (bus.data2 >= W_VAL) ? W_VAL : bus.data2;
      OP_ROR:  n_full = bus.data2 % W_VAL;
      default: n_full = '0;
    endcase
    n_load = CNTW'(n_full);
  end

  // One iteration of the selected operation on the current accumulator.
  always_comb begin
    // Carry out of the add lands in the top bit before the right shift.
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
               {1'b0, (acc_q[0] ? mcand_q : {WIDTH{1'b0}})};
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};
    shift_next = acc_q[WIDTH-1:0];
    case (op_q)
      OP_SLL:  shift_next = {acc_q[WIDTH-2:0], 1'b0};
      OP_SRL:  shift_next = {1'b0, acc_q[WIDTH-1:1]};
      OP_ROR:  shift_next = {acc_q[0], acc_q[WIDTH-1:1]};
      default: shift_next = acc_q[WIDTH-1:0];
    endcase
    step_next = (op_q == OP_MUL) ? mul_next : {{WIDTH{1'b0}}, shift_next};
  end

  // Control FSM with registered outputs; reset overrides everything.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      mcand_q     <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      result_hi_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            op_q    <= bus.op;
            mcand_q <= bus.data1;
            cnt_q   <= n_load;
            busy_q  <= 1'b1;
            if (bus.op == OP_MUL) begin
              acc_q <= {{WIDTH{1'b0}}, bus.data2};
            end else begin
              acc_q <= {{WIDTH{1'b0}}, bus.data1};
            end
            if (n_load == '0) begin
              // Zero-step request completes immediately with the operand.
              state_q     <= S_DONE;
              result_q    <= bus.data1;
              result_hi_q <= '0;
              done_q      <= 1'b1;
            end else begin
              state_q <= S_RUN;
            end
          end
        end
        S_RUN: begin
          acc_q <= step_next;
          cnt_q <= cnt_q - CNTW'(1);
          if (cnt_q == CNTW'(1)) begin
            state_q     <= S_DONE;
            result_q    <= step_next[WIDTH-1:0];
            result_hi_q <= step_next[2*WIDTH-1:WIDTH];
            done_q      <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule
